// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit 7-segment scan with edit-digit blink, colon blink and anti-ghost gap
module display_scan_controller #(
    parameter int SCAN_DIV     = 8000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_HALF   = 64
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [15:0] i_Digits,
    input  logic [1:0]  i_Display_Enable_Digits,
    input  logic        i_Display_Enable_Dot,
    input  logic        i_Second_Tick,
    output logic [3:0]  o_Anode,
    output logic [6:0]  o_Segments,
    output logic        o_Dot,
    output logic        o_Frame_End
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [CW-1:0] C_LAST     = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_BLANK    = CW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [CW-1:0] c;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [3:0]    nibble;
    logic [BW-1:0] frame_cnt;
    logic          blink_on;
    logic          dot_on;
    logic [1:0]    edit_q;
    logic          frame_end;
    logic          blink_sel;
    logic          anode_on;
    logic [6:0]    glyph;

    assign idx_next  = idx + 2'd1;
    assign frame_end = (idx == 2'd3) && (c == C_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            c         <= '0;
            idx       <= 2'd0;
            nibble    <= i_Digits[3:0];
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            dot_on    <= 1'b1;
            edit_q    <= 2'b00;
        end else begin
            if (c == C_LAST) begin
                c      <= '0;
                idx    <= idx_next;
                nibble <= i_Digits[{idx_next, 2'b00} +: 4];
            end else begin
                c <= c + CW'(1);
            end

            // A new edit selection restarts the blink with digits visible
            if (i_Display_Enable_Digits != edit_q) begin
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (i_Display_Enable_Digits == 2'b00) begin
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_end) begin
                if (frame_cnt == BLINK_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + BW'(1);
                end
            end
            edit_q <= i_Display_Enable_Digits;

            if (!i_Display_Enable_Dot)
                dot_on <= 1'b1;
            else if (i_Second_Tick)
                dot_on <= ~dot_on;
        end
    end

    always_comb begin
        blink_sel = 1'b0;
        case (i_Display_Enable_Digits)
            2'b01:   blink_sel = ~idx[1];
            2'b10:   blink_sel = idx[1];
            2'b11:   blink_sel = 1'b1;
            default: blink_sel = 1'b0;
        endcase
    end

    assign anode_on = !i_Reset && (c >= C_BLANK) && !(!blink_on && blink_sel);

    always_comb begin
        glyph = 7'b0111111;
        case (nibble)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase
    end

    assign o_Anode     = anode_on ? ~(4'b0001 << idx) : 4'hF;
    assign o_Segments  = anode_on ? glyph : 7'h7F;
    assign o_Dot       = ~(anode_on && (idx == 2'd2) && i_Display_Enable_Dot && dot_on);
    assign o_Frame_End = frame_end && !i_Reset;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - scoreboard bench for display_scan_controller
module tb_display_scan_controller;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [1:0]  edit;
    logic        dot_en;
    logic        tick;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dot;
    logic        fe;

    display_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_HALF(BH)) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Digits(digits),
        .i_Display_Enable_Digits(edit),
        .i_Display_Enable_Dot(dot_en),
        .i_Second_Tick(tick),
        .o_Anode(anode),
        .o_Segments(seg),
        .o_Dot(dot),
        .o_Frame_End(fe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_fe = -1;

    int mc, midx, mcnt;
    bit mblink, mdot;
    logic [1:0] medit_q;
    logic [3:0] mnib;
    logic [6:0] glyph_tab [16];
    logic [12:0] exp_q [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [12:0] model_out();
        bit on;
        bit sel;
        logic [3:0] a;
        logic [6:0] s;
        if (rst) return {4'hF, 7'h7F, 1'b1, 1'b0};
        case (edit)
            2'b01:   sel = (midx < 2);
            2'b10:   sel = (midx >= 2);
            2'b11:   sel = 1'b1;
            default: sel = 1'b0;
        endcase
        on = (mc >= BC) && (mblink || !sel);
        a  = on ? ~(4'(1) << midx) : 4'hF;
        s  = on ? glyph_tab[mnib] : 7'h7F;
        return {a, s, !(on && midx == 2 && dot_en && mdot), (midx == 3 && mc == SD - 1)};
    endfunction

    task automatic model_edge();
        bit f;
        f = (midx == 3 && mc == SD - 1);
        if (rst) begin
            mc = 0; midx = 0; mnib = digits[3:0];
            mcnt = 0; mblink = 1; mdot = 1; medit_q = 2'b00;
        end else begin
            if (mc == SD - 1) begin
                mc = 0;
                midx = (midx + 1) % 4;
                mnib = digits[4*midx +: 4];
            end else begin
                mc++;
            end
            if (edit != medit_q || edit == 2'b00) begin
                mcnt = 0; mblink = 1;
            end else if (f) begin
                if (mcnt == BH - 1) begin
                    mcnt = 0; mblink = !mblink;
                end else begin
                    mcnt++;
                end
            end
            medit_q = edit;
            if (!dot_en) mdot = 1;
            else if (tick) mdot = !mdot;
        end
    endtask

    task automatic run(input int n);
        logic [12:0] e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_out());
            @(negedge clk);
            e = exp_q.pop_front();
            check("outputs", 16'({anode, seg, dot, fe}), 16'(e));
            if (rst) last_fe = -1;
            if (fe) begin
                if (last_fe >= 0) check("frame_period", 16'(cyc - last_fe), 16'(4 * SD));
                last_fe = cyc;
            end
            @(posedge clk);
            model_edge();
            cyc++;
            #1;
        end
    endtask

    task automatic wait_state(input int wi, input int wc);
        int budget;
        budget = 200;
        while (!(midx == wi && mc == wc) && budget > 0) begin
            run(1);
            budget--;
        end
        if (budget == 0) check("wait_timeout", 16'd1, 16'd0);
    endtask

    initial begin
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        mc = 0; midx = 0; mcnt = 0; mblink = 1; mdot = 1; medit_q = 2'b00; mnib = 4'h0;
        rst = 1'b1; digits = 16'h1234; edit = 2'b00; dot_en = 1'b0; tick = 1'b0;

        @(posedge clk);
        model_edge();
        #1;
        check("rst_anode", 16'(anode), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_dot", 16'(dot), 16'd1);
        check("rst_fe", 16'(fe), 16'd0);
        run(3);
        rst = 1'b0;
        #1;
        check("post_rst_anode", 16'(anode), 16'hF);
        run(2);
        check("slot0_anode", 16'(anode), 16'hE);
        check("slot0_seg", 16'(seg), 16'b0011001);
        run(6);
        check("slot1_blank", 16'(anode), 16'hF);
        run(2);
        check("slot1_seg", 16'(seg), 16'b0110000);
        run(70);

        wait_state(3, SD - 1);
        edit = 2'b01;
        run(1 + 128);
        run(65);
        check("blink_mode", 16'(mblink), 16'd0);
        edit = 2'b10;
        run(140);
        edit = 2'b11;
        run(140);

        edit = 2'b00;
        dot_en = 1'b1;
        run(64);
        tick = 1'b1; run(1); tick = 1'b0;
        run(64);
        tick = 1'b1; run(1); tick = 1'b0;
        run(40);
        tick = 1'b1; run(1); tick = 1'b0;
        run(10);
        tick = 1'b1; dot_en = 1'b0; run(1);
        tick = 1'b0; dot_en = 1'b1;
        run(40);

        digits = 16'h123C;
        run(64);
        wait_state(0, 4);
        digits = 16'h1235;
        run(40);

        wait_state(2, 5);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(2);
        check("restart_anode", 16'(anode), 16'hE);
        check("restart_seg", 16'(seg), 16'b0010010);
        run(70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
